// File: rtl/pipe_div_unit.sv
// Iterative radix-2 restoring divider for DIV/DIVU. It produces one quotient bit per clock,
// holds the pipeline through busy, and pulses done once q/r are valid.
module pipe_div_unit #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             sign,
    input  logic             flush,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] r,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] counter
);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] q_q, q_d;
    logic [WIDTH-1:0] r_q, r_d;
    logic             qneg_q, qneg_d;
    logic             rneg_q, rneg_d;
    logic             div0_q, div0_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [WIDTH-1:0] abs_a, abs_b;
    logic [WIDTH:0]   trial;

    assign abs_a = (sign && dividend[WIDTH-1]) ? -dividend : dividend;
    assign abs_b = (sign && divisor[WIDTH-1])  ? -divisor  : divisor;
    // Extra top bit of the trial difference acts as the borrow (restore) flag.
    assign trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dvs_q};

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        dvs_d   = dvs_q;
        dvd_d   = dvd_q;
        q_d     = q_q;
        r_d     = r_q;
        qneg_d  = qneg_q;
        rneg_d  = rneg_q;
        div0_d  = div0_q;
        cnt_d   = cnt_q;

        case (state_q)
            S_IDLE, S_DONE: begin
                state_d = S_IDLE;
                if (start) begin
                    state_d = S_RUN;
                    rem_d   = '0;
                    quo_d   = abs_a;
                    dvs_d   = abs_b;
                    dvd_d   = dividend;
                    qneg_d  = sign & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
                    rneg_d  = sign & dividend[WIDTH-1];
                    div0_d  = (divisor == '0);
                    cnt_d   = CNT_W'(WIDTH);
                end
            end
            S_RUN: begin
                if (cnt_q != '0) begin
                    if (!trial[WIDTH]) begin
                        rem_d = trial[WIDTH-1:0];
                        quo_d = {quo_q[WIDTH-2:0], 1'b1};
                    end else begin
                        rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
                        quo_d = {quo_q[WIDTH-2:0], 1'b0};
                    end
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    // Divide-by-zero reports the untouched dividend, not |dividend|.
                    if (div0_q) begin
                        q_d = '1;
                        r_d = dvd_q;
                    end else begin
                        q_d = qneg_q ? -quo_q : quo_q;
                        r_d = rneg_q ? -rem_q : rem_q;
                    end
                    state_d = S_DONE;
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush) begin
            state_d = S_IDLE;
            cnt_d   = '0;
            q_d     = q_q;
            r_d     = r_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            rem_q   <= '0;
            quo_q   <= '0;
            dvs_q   <= '0;
            dvd_q   <= '0;
            q_q     <= '0;
            r_q     <= '0;
            qneg_q  <= 1'b0;
            rneg_q  <= 1'b0;
            div0_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            dvs_q   <= dvs_d;
            dvd_q   <= dvd_d;
            q_q     <= q_d;
            r_q     <= r_d;
            qneg_q  <= qneg_d;
            rneg_q  <= rneg_d;
            div0_q  <= div0_d;
            cnt_q   <= cnt_d;
        end
    end

    assign q       = q_q;
    assign r       = r_q;
    assign busy    = (state_q == S_RUN);
    assign done    = (state_q == S_DONE);
    assign counter = cnt_q;

endmodule

// File: doc/pipe_div_unit.md
Name: pipe_div_unit

Overview:
- Iterative 32-bit integer divider serving DIV/DIVU in the execute stage of the pipelined CPU.
- The EXE stage launches an operation with start. The unit drives busy into the ID-stage stall logic so the pipeline holds while the divide runs.
- Quotient and remainder are produced for the EX/MEM register, which routes them to the hi/lo write path (q to lo, r to hi).
- Radix-2 restoring algorithm, one quotient bit per clock.

Parameters:
- WIDTH, 32, operand/result width in bits
- CNT_W, 6, width of iteration counter (must hold WIDTH)

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous, active-high reset
- start  input  1  launch request, sampled on rising clk
- sign  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start
- flush  input  1  abort in-flight operation (pipeline flush/exception)
- dividend  input  WIDTH  operand a, sampled with start
- divisor  input  WIDTH  operand b, sampled with start
- q  output  WIDTH  quotient
- r  output  WIDTH  remainder
- busy  output  1  operation in flight; request stall upstream
- done  output  1  one-cycle pulse, q/r valid
- counter  output  CNT_W  iterations remaining (debug/EXE visibility)

Behaviour:
- Reset (async, rst=1): state IDLE; q=0, r=0, busy=0, done=0, counter=0. Internal shift registers cleared. Effective immediately, regardless of clk.
- States: IDLE, RUN, DONE.
- IDLE / DONE + start=1 at edge k:
  - Latch operands and sign. Take absolute values when sign=1.
  - Go to RUN; counter=WIDTH; busy=1 from cycle k+1.
- RUN:
  - Each edge: shift remainder:dividend left 1, trial-subtract |divisor|, set quotient bit, counter decrements.
  - After WIDTH iterations (edge k+32) apply the sign fix-up and go to DONE at edge k+33.
  - busy is high for cycles k+1..k+33 (33 cycles). busy drops in the cycle where done=1.
- DONE:
  - done=1 for exactly one cycle. q/r hold their final values until the next accepted start or reset.
  - Goes to IDLE on the next edge unless start=1, which launches a new op (back-to-back allowed).
- start while in RUN: ignored. Operands are not re-latched.
- flush=1 (any state, synchronous):
  - Next state IDLE; busy=0; done=0; counter=0.
  - q/r keep their previous values.
  - flush has priority over start in the same cycle.
- Sign rules (sign=1):
  - Quotient negated if the operand signs differ.
  - Remainder takes the sign of the dividend.
  - Identity dividend = q*divisor + r holds.
- Divide by zero (divisor=0), both modes:
  - Still takes the full latency.
  - q=32'hFFFFFFFF, r=dividend (original, unmodified).
- Signed overflow (dividend=32'h80000000, divisor=32'hFFFFFFFF, sign=1): q=32'h80000000, r=0.
- Unsigned: operands treated as raw 32-bit magnitudes; no fix-up.
- Outputs are registered; there is no combinational path from inputs to q/r/done.
- busy depends only on state, so it is glitch-free for the stall logic.

Test Plan:
- Reset: rst pulsed mid-RUN (cycle k+10) -> busy=0, done=0, q=0, r=0, counter=0 asynchronously. No done pulse ever follows.
- Unsigned: start, sign=0, 100/7 -> busy high 33 cycles, done pulse at k+33, q=14, r=2. Then 32'hFFFFFFFF/2 -> q=32'h7FFFFFFF, r=1.
- Signed: -7/2 -> q=-3 (32'hFFFFFFFD), r=-1. 7/-2 -> q=-3, r=1. -7/-2 -> q=3, r=-1.
- Corner cases:
  - 5/0 signed -> q=32'hFFFFFFFF, r=5.
  - 32'h80000000/32'hFFFFFFFF signed -> q=32'h80000000, r=0.
  - Both cases keep the 33-cycle latency.
- Handshake:
  - start re-asserted during RUN -> ignored; original result returned.
  - start asserted in the DONE cycle -> new op begins; its done arrives 33 cycles later.
- Flush: flush at k+5 with start=1 in the same cycle -> IDLE next cycle, busy=0, no done. q/r still hold the previous result.
